// File: rtl/shift_if.sv
// shift_if: start/busy/done handshake and data bundle for shift_sequencer.
interface shift_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  din;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  dout;
    modport master (output start, op, shamt, din, input busy, done, dout);
    modport slave  (input start, op, shamt, din, output busy, done, dout);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative shift/rotate unit with start/busy/done handshake.
// Define SHIFT_STEP4_EN to move 4 positions per SHIFT cycle while cnt >= 4.
module shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input logic    clk,
    input logic    reset_n,
    shift_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [DATA_W-1:0]  w_one;
    logic [DATA_W-1:0]  w_next;
    logic [SHAMT_W-1:0] w_dec;
    always_comb begin
        w_one = r_op == 3'd0 ? {r_work[DATA_W-2:0], 1'b0} :
                r_op == 3'd1 ? {1'b0, r_work[DATA_W-1:1]} :
                r_op == 3'd2 ? {r_work[DATA_W-1], r_work[DATA_W-1:1]} :
                r_op == 3'd3 ? {r_work[DATA_W-2:0], r_work[DATA_W-1]} :
                               {r_work[0], r_work[DATA_W-1:1]};
    end
`ifdef SHIFT_STEP4_EN
    logic [DATA_W-1:0] w_four;
    logic              w_big;
    always_comb begin
        w_four = r_op == 3'd0 ? {r_work[DATA_W-5:0], 4'b0} :
                 r_op == 3'd1 ? {4'b0, r_work[DATA_W-1:4]} :
                 r_op == 3'd2 ? {{4{r_work[DATA_W-1]}}, r_work[DATA_W-1:4]} :
                 r_op == 3'd3 ? {r_work[DATA_W-5:0], r_work[DATA_W-1:DATA_W-4]} :
                                {r_work[3:0], r_work[DATA_W-1:4]};
        w_big  = r_cnt >= SHAMT_W'(4);
        w_next = w_big ? w_four : w_one;
        w_dec  = w_big ? SHAMT_W'(4) : SHAMT_W'(1);
    end
`else
    always_comb begin
        w_next = w_one;
        w_dec  = SHAMT_W'(1);
    end
`endif
    // Zero shift and pass-through ops skip SHIFT and complete one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_work <= bus.din;
                        r_cnt  <= bus.shamt;
                        r_op   <= bus.op;
                        if (bus.shamt != '0 && bus.op <= 3'd4) begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt - w_dec;
                    if (r_cnt == w_dec) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_work;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven directed bench for shift_sequencer.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    shift_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
    shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  sh;
        logic [31:0] din;
        logic [31:0] res;
    } vec_t;
    vec_t v[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [4:0] n);
        if (op > 3'd4 || n == 5'd0) return 0;
`ifdef SHIFT_STEP4_EN
        return int'(n) / 4 + int'(n) % 4;
`else
        return int'(n);
`endif
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run(input string name, input logic [2:0] op, input logic [4:0] sh,
                       input logic [31:0] din, input logic [31:0] res, input int pulse_at);
        int idx = 0;
        int bc = 0;
        int lat = exp_lat(op, sh);
        bus.start = 1'b1; bus.op = op; bus.shamt = sh; bus.din = din;
        @(negedge clk);
        bus.start = 1'b0; bus.din = ~din; bus.shamt = ~sh;
        while (!bus.done && idx < 80) begin
            if (bus.busy) bc++;
            @(negedge clk);
            idx++;
            bus.start = (idx == pulse_at);
            if (idx == pulse_at) begin
                bus.op = 3'd0; bus.shamt = 5'd1; bus.din = 32'h12345678;
            end
        end
        bus.start = 1'b0;
        check({name, " latency"}, idx, lat);
        check({name, " busy cycles"}, bc, lat);
        check({name, " busy at done"}, {31'b0, bus.busy}, 32'd0);
        check({name, " dout"}, bus.dout, res);
        @(negedge clk);
        check({name, " done pulse width"}, {31'b0, bus.done}, 32'd0);
        check({name, " dout hold"}, bus.dout, res);
    endtask

    initial begin
        int dcnt;
        v[0]  = '{3'd0, 5'd4,  32'h00000001, 32'h00000010};
        v[1]  = '{3'd2, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        v[2]  = '{3'd4, 5'd1,  32'h00000001, 32'h80000000};
        v[3]  = '{3'd3, 5'd4,  32'h80000001, 32'h00000018};
        v[4]  = '{3'd1, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
        v[5]  = '{3'd6, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        v[6]  = '{3'd1, 5'd8,  32'hF0000000, 32'h00F00000};
        v[7]  = '{3'd0, 5'd31, 32'hA5A5A5A5, 32'h80000000};
        v[8]  = '{3'd2, 5'd5,  32'h7FFFFFFF, 32'h03FFFFFF};
        v[9]  = '{3'd4, 5'd4,  32'h12345678, 32'h81234567};
        v[10] = '{3'd3, 5'd8,  32'h12345678, 32'h34567812};
        v[11] = '{3'd5, 5'd0,  32'h0000FFFF, 32'h0000FFFF};
        v[12] = '{3'd7, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
        v[13] = '{3'd1, 5'd31, 32'h80000000, 32'h00000001};
        v[14] = '{3'd2, 5'd30, 32'h40000000, 32'h00000001};
        v[15] = '{3'd4, 5'd6,  32'h0000000F, 32'h3C000000};
        v[16] = '{3'd0, 5'd16, 32'h0000FFFF, 32'hFFFF0000};
        bus.start = 1'b0; bus.op = '0; bus.shamt = '0; bus.din = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset dout", bus.dout, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) run($sformatf("vec%0d", i), v[i].op, v[i].sh, v[i].din, v[i].res, -1);
        run("start while busy", 3'd1, 5'd8, 32'hF0000000, 32'h00F00000, 3);
        run("back to back", 3'd4, 5'd1, 32'h00000001, 32'h80000000, -1);
        bus.start = 1'b1; bus.op = 3'd0; bus.shamt = 5'd20; bus.din = 32'h00000001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midop reset busy", {31'b0, bus.busy}, 32'd0);
        check("midop reset done", {31'b0, bus.done}, 32'd0);
        check("midop reset dout", bus.dout, 32'd0);
        reset_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("no done after reset", dcnt, 32'd0);
        run("after reset", 3'd0, 5'd3, 32'h00000001, 32'h00000008, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
